// File: rtl/synch_toggle_bank.sv
// synch_toggle_bank: multi-channel toggle-event generator used to drive
// synchronisation tests.
//
// Each channel inverts its WIDTH-bit output every P cycles, N times, and
// flips a per-channel change flag on every inversion. A shared session
// watchdog ends a run that exceeds the latched timeout. all_done reports
// that a session finished normally.
//
// Ports:
//   clk, reset          clock; async active-high reset
//   start[CHANNELS]     per-channel start request
//   period, count       flat per-channel P / N fields, sampled on accepted start
//   timeout             watchdog limit, sampled when the session arms (0 = off)
//   abort               stop all channels, drop same-edge starts
//   sig_out             flat per-channel output vectors
//   changed             per-channel change flag (inverts on each toggle)
//   busy                per-channel RUN indication
//   all_done            session completed normally (level)
//   timed_out           session ended by watchdog (sticky level)

module synch_toggle_chan #(
  parameter int WIDTH    = 2,
  parameter int PERIOD_W = 8,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,   // already gated by abort at the top
  input  logic                kill,    // abort or watchdog expiry
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  count,
  output logic [WIDTH-1:0]    sig,
  output logic                chg,
  output logic                busy,
  output logic                arm_req, // start accepted with N>0 this edge
  output logic                live     // still running after this edge
);
  typedef enum logic {C_IDLE, C_RUN} cst_t;
  cst_t                state;
  logic [PERIOD_W-1:0] p_lat, timer;
  logic [COUNT_W-1:0]  rem;
  logic                expire, last;

  assign busy    = (state == C_RUN);
  assign expire  = busy && (timer == PERIOD_W'(1));
  assign last    = expire && (rem == COUNT_W'(1));
  assign live    = busy && !last;
  assign arm_req = start && !busy && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= C_IDLE;
      p_lat <= '0;
      timer <= '0;
      rem   <= '0;
      sig   <= '0;
      chg   <= 1'b0;
    end else if (kill) begin
      // outputs hold their value; no toggle on the kill edge
      state <= C_IDLE;
    end else begin
      case (state)
        C_IDLE: if (arm_req) begin
          // period 0 behaves as period 1
          p_lat <= (period == '0) ? PERIOD_W'(1) : period;
          timer <= (period == '0) ? PERIOD_W'(1) : period;
          rem   <= count;
          state <= C_RUN;
        end
        C_RUN: begin
          if (expire) begin
            sig   <= ~sig;
            chg   <= ~chg;
            timer <= p_lat;
            rem   <= rem - COUNT_W'(1);
            if (last) state <= C_IDLE;
          end else begin
            timer <= timer - PERIOD_W'(1);
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end
endmodule

module synch_toggle_bank #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 2,
  parameter int PERIOD_W  = 8,
  parameter int COUNT_W   = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS*PERIOD_W-1:0] period,
  input  logic [CHANNELS*COUNT_W-1:0]  count,
  input  logic [TIMEOUT_W-1:0]         timeout,
  input  logic                         abort,
  output logic [CHANNELS*WIDTH-1:0]    sig_out,
  output logic [CHANNELS-1:0]          changed,
  output logic [CHANNELS-1:0]          busy,
  output logic                         all_done,
  output logic                         timed_out
);
  typedef enum logic {S_IDLE, S_ARMED} sst_t;
  sst_t                 sess;
  logic [TIMEOUT_W-1:0] to_lat, wd;
  logic [CHANNELS-1:0]  arm_req, live;
  logic                 to_fire, kill;

  // A channel finishing on the expiry edge does not count as still busy,
  // so a final toggle coinciding with the limit completes normally.
  assign to_fire = (sess == S_ARMED) && (to_lat != '0) &&
                   (wd == to_lat - TIMEOUT_W'(1)) && (|live);
  assign kill    = abort | to_fire;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    synch_toggle_chan #(
      .WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .start   (start[c] & ~abort),
      .kill    (kill),
      .period  (period[c*PERIOD_W +: PERIOD_W]),
      .count   (count[c*COUNT_W +: COUNT_W]),
      .sig     (sig_out[c*WIDTH +: WIDTH]),
      .chg     (changed[c]),
      .busy    (busy[c]),
      .arm_req (arm_req[c]),
      .live    (live[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sess      <= S_IDLE;
      to_lat    <= '0;
      wd        <= '0;
      all_done  <= 1'b0;
      timed_out <= 1'b0;
    end else if (abort) begin
      sess     <= S_IDLE;
      all_done <= 1'b0;
    end else if (sess == S_IDLE) begin
      if (|arm_req) begin
        sess      <= S_ARMED;
        all_done  <= 1'b0;
        timed_out <= 1'b0;
        to_lat    <= timeout;
        wd        <= '0;
      end
    end else begin
      if (to_fire) begin
        sess      <= S_IDLE;
        timed_out <= 1'b1;
      end else if (~|busy && ~|arm_req) begin
        sess     <= S_IDLE;
        all_done <= 1'b1;
      end else if (wd != '1) begin
        wd <= wd + TIMEOUT_W'(1);
      end
    end
  end
endmodule
